mag_power_ctrl: RTL and testbench
=================================

# mag_power_ctrl

Clocked, parametrised magnetron controller for the microwave datapath. It replaces the asynchronous set/reset latch with a synchronous run/pause/idle state machine. In RUN it modulates the magnetron with a slot-based duty cycle selected by a power level. It sits between the keypad/door front end and the magnetron driver, and takes `timer_done` from the cook timer.

## Interface
- `LEVELS`, default 10: number of power levels; duty window holds `LEVELS` slots.
- `SLOT_CYCLES`, default 4: clock cycles per slot; period = `LEVELS*SLOT_CYCLES` cycles.
- `LW`, default `$clog2(LEVELS+1)`: width of `power_level`.

Ports:
- `clk` in 1: single system clock, rising edge.
- `resetn` in 1: reset, asynchronous assert, active-low.
- `startn` in 1: start key, active-low; a falling edge (high→low between samples) is a start request.
- `stopn` in 1: stop key, active-low level.
- `clearn` in 1: clear key, active-low level.
- `door_closed` in 1: 1 = door closed.
- `timer_done` in 1: cook timer expired, active-high level.
- `power_level` in `LW`: requested level 0..`LEVELS`; values above `LEVELS` are clamped to `LEVELS`.
- `mag_on` out 1: magnetron drive, registered.
- `running` out 1: state == RUN, registered.
- `paused` out 1: state == PAUSE, registered.
- `done` out 1: one-cycle pulse when RUN or PAUSE ends because of `timer_done`.

## Operation
- All inputs are synchronous to `clk`; synchronisers and debouncing belong upstream.
- `startn` is sampled into `startn_q` each cycle. `start_req = startn_q & ~startn`.
- States are IDLE, RUN and PAUSE. Each clock applies the first matching rule, in this priority order:
  1. `clearn==0`: go to IDLE from any state.
  2. `timer_done==1` in RUN or PAUSE: go to IDLE and pulse `done`. In IDLE, no effect.
  3. `stopn==0`: RUN→PAUSE, PAUSE→IDLE, IDLE→IDLE.
  4. `door_closed==0` in RUN: go to PAUSE.
  5. `start_req & door_closed` in IDLE or PAUSE: go to RUN.
  6. Otherwise, hold state.
- Start is blocked whenever a higher-priority rule fires in the same cycle. Holding `startn` low never re-triggers; it must return high first.
- On every entry to RUN:
  - `power_level` is latched into `lvl` (clamped).
  - The slot counter `sc` (0..`SLOT_CYCLES-1`) and phase counter `ph` (0..`LEVELS-1`) are cleared to 0.
- In RUN, `sc` increments each cycle. When `sc` wraps, `ph` increments; `ph` wraps to 0 after `LEVELS-1`.
- Counters freeze in PAUSE and clear in IDLE.
- `power_level` changes during RUN are ignored until the next RUN entry.
- `mag_on = (state==RUN) & (ph < lvl)`, registered alongside state. Consequences:
  - `lvl==0`: RUN with the magnetron off.
  - `lvl==LEVELS`: continuous on.

## Timing
- Reset (asynchronous, `resetn==0`):
  - State = IDLE.
  - `mag_on`, `running`, `paused`, `done` = 0.
  - `startn_q` = 1.
  - `sc`, `ph`, `lvl` = 0.
- Reset mid-RUN drops `mag_on` immediately, without waiting for a clock edge.
- Start latency: the `startn` falling edge is sampled at edge N. `running` and (if `lvl>0`) `mag_on` are high after edge N.
- Stop, door-open, clear and `timer_done` are all sampled at edge N. `mag_on` and `running` are low after edge N, which gives one cycle of latency.
- `done` is high for exactly the one cycle after edge N.
- Duty pattern from RUN entry: `mag_on` is high for `lvl*SLOT_CYCLES` cycles, then low for `(LEVELS-lvl)*SLOT_CYCLES` cycles, repeating with period `LEVELS*SLOT_CYCLES`.
- Resume from PAUSE restarts the duty window at phase 0. It re-latches `power_level` and does not continue the old phase.
- `running` and `paused` are never both high.
- `mag_on` is never high unless `running` is high.

## Test plan
Parameters for all scenarios: `LEVELS=4`, `SLOT_CYCLES=2`.
- Reset, then a `startn` falling edge with `door_closed=1` and `power_level=2` → `running=1` the next cycle. `mag_on` repeats 1,1,1,1,0,0,0,0 (period 8) over 24 cycles.
- A `startn` edge with `door_closed=0` → stays IDLE. `startn` held low while the door closes → still IDLE. Release `startn`, then press again → RUN.
- RUN at `power_level=4`: open the door → PAUSE (`paused=1`, `mag_on=0`). Close the door → stays PAUSE. `startn` edge → RUN with `mag_on=1` continuously.
- RUN: `stopn` low for 1 cycle → PAUSE. `stopn` low again → IDLE. `clearn` low from RUN → IDLE directly, with `done=0`.
- RUN: `timer_done=1` for 1 cycle → IDLE, `done` high for exactly 1 cycle. A `startn` edge in the same cycle as `timer_done`, `clearn=0` or `stopn=0` → no RUN entry.
- Assert `resetn=0` mid-RUN, between clock edges → `mag_on`, `running` and `paused` drop to 0 immediately. After release, a `startn` edge with `power_level=7` runs clamped to level 4 (continuous on). A `power_level=0` start gives `running=1` with `mag_on=0`.

Source files
------------

// File: rtl/mag_power_ctrl.sv
// Magnetron power controller: synchronous IDLE/RUN/PAUSE state machine with a
// slot-based duty-cycle modulator. The duty window is LEVELS slots of
// SLOT_CYCLES clocks each; the magnetron is on for the first lvl slots.
module mag_power_ctrl #(
  parameter int LEVELS      = 10,
  parameter int SLOT_CYCLES = 4,
  parameter int LW          = $clog2(LEVELS + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          startn,
  input  logic          stopn,
  input  logic          clearn,
  input  logic          door_closed,
  input  logic          timer_done,
  input  logic [LW-1:0] power_level,
  output logic          mag_on,
  output logic          running,
  output logic          paused,
  output logic          done
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int PW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  localparam logic [LW-1:0] LEVELS_L = LW'(LEVELS);
  localparam logic [SW-1:0] SC_MAX   = SW'(SLOT_CYCLES - 1);
  localparam logic [PW-1:0] PH_MAX   = PW'(LEVELS - 1);

  logic [1:0]    state_reg, state_next;
  logic          startn_q;
  logic [SW-1:0] sc_reg, sc_next;
  logic [PW-1:0] ph_reg, ph_next;
  logic [LW-1:0] lvl_reg, lvl_next;
  logic          mag_on_reg, running_reg, paused_reg, done_reg;
  logic          done_next;
  logic          start_req;
  logic          enter_run;
  logic [LW-1:0] lvl_clamped;

  // A start request is a high-to-low transition of the start key between samples.
  assign start_req   = startn_q & ~startn;
  assign lvl_clamped = (power_level > LEVELS_L) ? LEVELS_L : power_level;

  // Next-state selection; rules are evaluated in strict priority order.
  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    if (!clearn) begin
      state_next = IDLE;
    end else if (timer_done && (state_reg == RUN || state_reg == PAUSE)) begin
      state_next = IDLE;
      done_next  = 1'b1;
    end else if (!stopn) begin
      state_next = (state_reg == RUN) ? PAUSE : IDLE;
    end else if (!door_closed && state_reg == RUN) begin
      state_next = PAUSE;
    end else if (start_req && door_closed && state_reg != RUN) begin
      state_next = RUN;
    end
  end

  assign enter_run = (state_next == RUN) && (state_reg != RUN);

  // Duty-window counters: restart on RUN entry, advance in RUN, freeze in PAUSE, clear in IDLE.
  always_comb begin
    sc_next  = sc_reg;
    ph_next  = ph_reg;
    lvl_next = lvl_reg;
    if (enter_run) begin
      sc_next  = '0;
      ph_next  = '0;
      lvl_next = lvl_clamped;
    end else if (state_next == RUN) begin
      if (sc_reg == SC_MAX) begin
        sc_next = '0;
        ph_next = (ph_reg == PH_MAX) ? '0 : ph_reg + PW'(1);
      end else begin
        sc_next = sc_reg + SW'(1);
      end
    end else if (state_next == IDLE) begin
      sc_next = '0;
      ph_next = '0;
    end
  end

  // State, counters and all outputs are registered together; reset clears drive at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      startn_q    <= 1'b1;
      sc_reg      <= '0;
      ph_reg      <= '0;
      lvl_reg     <= '0;
      mag_on_reg  <= 1'b0;
      running_reg <= 1'b0;
      paused_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      startn_q    <= startn;
      sc_reg      <= sc_next;
      ph_reg      <= ph_next;
      lvl_reg     <= lvl_next;
      mag_on_reg  <= (state_next == RUN) && (LW'(ph_next) < lvl_next);
      running_reg <= (state_next == RUN);
      paused_reg  <= (state_next == PAUSE);
      done_reg    <= done_next;
    end
  end

  assign mag_on  = mag_on_reg;
  assign running = running_reg;
  assign paused  = paused_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_mag_power_ctrl.sv
// Directed, table-driven bench for mag_power_ctrl with LEVELS=4, SLOT_CYCLES=2.
// Each vector holds the inputs applied before a rising edge and the outputs
// {mag_on, running, paused, done} expected just after that edge.
module tb_mag_power_ctrl;

  localparam int LEVELS      = 4;
  localparam int SLOT_CYCLES = 2;
  localparam int LW          = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          startn, stopn, clearn, door_closed, timer_done;
  logic [LW-1:0] power_level;
  logic          mag_on, running, paused, done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic          s_n;
    logic          st_n;
    logic          cl_n;
    logic          door;
    logic          td;
    logic [LW-1:0] pl;
    logic [3:0]    exp;
    string         name;
  } vec_t;

  vec_t vecs[$];

  mag_power_ctrl #(
    .LEVELS(LEVELS),
    .SLOT_CYCLES(SLOT_CYCLES),
    .LW(LW)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .startn(startn),
    .stopn(stopn),
    .clearn(clearn),
    .door_closed(door_closed),
    .timer_done(timer_done),
    .power_level(power_level),
    .mag_on(mag_on),
    .running(running),
    .paused(paused),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic s_n, input logic st_n, input logic cl_n,
                              input logic door, input logic td, input logic [LW-1:0] pl,
                              input logic [3:0] exp, input string name);
    vec_t v;
    v.s_n = s_n; v.st_n = st_n; v.cl_n = cl_n; v.door = door; v.td = td;
    v.pl = pl; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {mag,run,pause,done}=%b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Apply every queued vector, one clock each, then empty the queue.
  task automatic apply_all();
    logic [3:0] got;
    for (int i = 0; i < vecs.size(); i++) begin
      startn      = vecs[i].s_n;
      stopn       = vecs[i].st_n;
      clearn      = vecs[i].cl_n;
      door_closed = vecs[i].door;
      timer_done  = vecs[i].td;
      power_level = vecs[i].pl;
      @(posedge clk);
      #1;
      got = {mag_on, running, paused, done};
      check(vecs[i].name, got, vecs[i].exp);
      $display("vec %0d %s: in s%b st%b cl%b d%b t%b pl%0d -> %b", i, vecs[i].name,
               vecs[i].s_n, vecs[i].st_n, vecs[i].cl_n, vecs[i].door, vecs[i].td,
               vecs[i].pl, got);
      n_cmp++;
      if ((running && paused) || (mag_on && !running)) begin
        n_bad++;
        $display("FAIL invariant %s: run=%b pause=%b mag=%b", vecs[i].name, running, paused, mag_on);
      end
    end
    vecs.delete();
  endtask

  initial begin
    resetn = 1'b0;
    startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; timer_done = 1'b0; power_level = 3'd2;
    #12;
    check("reset_state", {mag_on, running, paused, done}, 4'b0000);
    #5 resetn = 1'b1;

    // Level 2: on 4 cycles, off 4 cycles.
    add(1,1,1,1,0,2,4'b0000,"idle_hold");
    add(0,1,1,1,0,2,4'b1100,"start_l2");
    for (int k = 1; k < 24; k++)
      add(1,1,1,1,0,2,{((k % 8) < 4) ? 1'b1 : 1'b0, 3'b100},"duty_l2");
    add(1,1,0,1,0,2,4'b0000,"clear_run");
    // Door interlock and held start key.
    add(0,1,1,0,0,2,4'b0000,"start_door_open");
    add(0,1,1,1,0,2,4'b0000,"held_door_close");
    add(1,1,1,1,0,2,4'b0000,"release");
    add(0,1,1,1,0,2,4'b1100,"repress");
    add(1,1,0,1,0,2,4'b0000,"clear2");
    // Full power, pause on door, resume.
    add(0,1,1,1,0,4,4'b1100,"start_l4");
    add(1,1,1,0,0,4,4'b0010,"door_open");
    add(1,1,1,1,0,4,4'b0010,"door_close_hold");
    add(0,1,1,1,0,4,4'b1100,"resume_l4");
    for (int k = 0; k < 9; k++) add(1,1,1,1,0,4,4'b1100,"cont_l4");
    // Resume re-latches level and restarts at phase 0.
    add(1,1,1,0,0,1,4'b0010,"pause_r");
    add(0,1,1,1,0,1,4'b1100,"resume_l1");
    add(1,1,1,1,0,1,4'b1100,"l1_k1");
    for (int k = 2; k < 8; k++) add(1,1,1,1,0,1,4'b0100,"l1_off");
    add(1,1,1,1,0,1,4'b1100,"l1_wrap");
    // Stop key: RUN->PAUSE->IDLE; clear without done.
    add(1,0,1,1,0,2,4'b0010,"stop_pause");
    add(1,1,1,1,0,2,4'b0010,"pause_hold");
    add(1,0,1,1,0,2,4'b0000,"stop_idle");
    add(0,1,1,1,0,2,4'b1100,"start4");
    add(1,1,1,1,0,2,4'b1100,"run4");
    add(1,1,0,1,0,2,4'b0000,"clear_nodone");
    // Timer expiry and start blocked by higher priority rules.
    add(0,1,1,1,0,2,4'b1100,"start5");
    add(1,1,1,1,1,2,4'b0001,"timer_done");
    add(1,1,1,1,0,2,4'b0000,"done_one");
    add(1,1,1,1,1,2,4'b0000,"timer_idle");
    add(0,1,1,1,0,2,4'b1100,"start5b");
    add(1,1,1,0,0,2,4'b0010,"pause5");
    add(0,1,1,1,1,2,4'b0001,"start_vs_timer");
    add(1,1,1,1,0,2,4'b0000,"after_timer");
    add(0,1,0,1,0,2,4'b0000,"start_vs_clear");
    add(1,1,1,1,0,2,4'b0000,"rel_a");
    add(0,0,1,1,0,2,4'b0000,"start_vs_stop");
    add(1,1,1,1,0,2,4'b0000,"rel_b");
    add(0,1,1,1,0,2,4'b1100,"start6");
    add(1,1,1,1,0,2,4'b1100,"run6");
    apply_all();

    // Asynchronous reset between edges while the magnetron is on.
    #2 resetn = 1'b0;
    #1 check("async_reset", {mag_on, running, paused, done}, 4'b0000);
    #3 resetn = 1'b1;

    // Clamping of out-of-range level, and level 0.
    add(1,1,1,1,0,7,4'b0000,"post_reset");
    add(0,1,1,1,0,7,4'b1100,"start_l7");
    for (int k = 0; k < 8; k++) add(1,1,1,1,0,7,4'b1100,"clamp_l4");
    add(1,1,0,1,0,7,4'b0000,"clear7");
    add(0,1,1,1,0,0,4'b0100,"start_l0");
    for (int k = 0; k < 8; k++) add(1,1,1,1,0,0,4'b0100,"l0_off");
    add(1,1,0,1,0,0,4'b0000,"clear_l0");
    apply_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
